// File: rtl/seg_scan_cntrl.sv
// Scan controller for a multiplexed octal seven-segment display.
// Shows one digit per slot with a blanking gap between slots; new values commit at frame boundaries.
module seg_scan_cntrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                    clk,
  input  logic                    reset_a,
  input  logic                    load,
  input  logic [3*NUM_DIGITS-1:0] data_in,
  input  logic                    blank_in,
  output logic [2:0]              digit_val,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  // state | meaning
  // OFF   | idle after reset, all anodes off, waiting for the first load
  // SHOW  | digit idx lit for PRESCALE cycles
  // GAP   | one all-off cycle between digits; frame boundary after the last digit
  typedef enum logic [1:0] {OFF, SHOW, GAP} state_t;

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PRESCALE - 1);

  state_t                    state, state_d;
  logic [IDX_W-1:0]          idx, idx_d;
  logic [PRE_W-1:0]          prescaler, prescaler_d;
  logic [3*NUM_DIGITS-1:0]   disp, disp_d;
  logic [3*NUM_DIGITS-1:0]   shadow, shadow_d;
  logic                      pending_d;
  logic                      blank_q;
  logic [NUM_DIGITS-1:0]     an_d;
  logic [2:0]                digit_val_d;
  logic                      frame_done_d;
  logic                      boundary;

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state      <= OFF;
      idx        <= '0;
      prescaler  <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      blank_q    <= 1'b0;
      an         <= '1;
      digit_val  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      prescaler  <= prescaler_d;
      disp       <= disp_d;
      shadow     <= shadow_d;
      pending    <= pending_d;
      blank_q    <= blank_in;
      an         <= an_d;
      digit_val  <= digit_val_d;
      frame_done <= frame_done_d;
    end
  end

  // Output registers are fed from the current state, so the display lags the FSM by one cycle.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    prescaler_d  = prescaler;
    disp_d       = disp;
    shadow_d     = shadow;
    pending_d    = pending;
    an_d         = '1;
    digit_val_d  = digit_val;
    frame_done_d = 1'b0;
    boundary     = 1'b0;

    case (state)
      OFF: begin
        if (load) begin
          disp_d      = data_in;
          idx_d       = '0;
          prescaler_d = '0;
          state_d     = SHOW;
        end
      end
      SHOW: begin
        if (!blank_q) an_d = ~(NUM_DIGITS'(1) << idx);
        digit_val_d = disp[3*int'(idx) +: 3];
        if (prescaler == LAST_PRE) begin
          prescaler_d = '0;
          state_d     = GAP;
        end else begin
          prescaler_d = prescaler + 1'b1;
        end
      end
      GAP: begin
        state_d = SHOW;
        if (idx == LAST_IDX) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
          boundary     = 1'b1;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    // A load landing on the commit edge bypasses the shadow and discards any older shadow value.
    if (state != OFF && load) begin
      if (boundary) begin
        disp_d    = data_in;
        pending_d = 1'b0;
      end else begin
        shadow_d  = data_in;
        pending_d = 1'b1;
      end
    end else if (boundary && pending) begin
      disp_d    = shadow;
      pending_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_cntrl.sv
// Scoreboard bench for seg_scan_cntrl: a frame-position model predicts every output cycle,
// a negedge monitor pops and compares.
module tb_seg_scan_cntrl;
  localparam int N     = 4;
  localparam int P     = 4;
  localparam int FRAME = N * (P + 1);

  logic             clk = 1'b0;
  logic             reset_a;
  logic             load;
  logic [3*N-1:0]   data_in;
  logic             blank_in;
  logic [2:0]       digit_val;
  logic [N-1:0]     an;
  logic             pending;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_cntrl #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk(clk), .reset_a(reset_a), .load(load), .data_in(data_in), .blank_in(blank_in),
    .digit_val(digit_val), .an(an), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [2:0]   dv;
    logic         pend;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: position t within the frame since the first load; digit = t/(P+1), gap at slot P.
  bit         started;
  int         t;
  logic [2:0] dig_m[N];
  logic [2:0] shd_m[N];
  logic       pend_m;
  logic       blank_m;
  logic [2:0] dv_m;

  always @(posedge clk) begin
    exp_t e;
    int   pos, dig;
    bit   gap, bnd;
    if (reset_a) begin
      started = 0; t = 0; pend_m = 0; blank_m = 0; dv_m = 0;
      for (int k = 0; k < N; k++) begin dig_m[k] = 0; shd_m[k] = 0; end
      e.an = '1; e.dv = 0; e.pend = 0; e.fd = 0;
    end else begin
      pos = t % (P + 1);
      dig = t / (P + 1);
      gap = started && (pos == P);
      bnd = gap && (dig == N - 1);
      e.an = '1;
      if (started && !gap && !blank_m) e.an[dig] = 1'b0;
      if (started && !gap) dv_m = dig_m[dig];
      e.dv = dv_m;
      e.fd = bnd;
      if (!started) begin
        if (load) begin
          for (int k = 0; k < N; k++) dig_m[k] = data_in[3*k +: 3];
          started = 1;
          t = 0;
        end
      end else begin
        t = (t + 1) % FRAME;
        if (load && bnd) begin
          for (int k = 0; k < N; k++) dig_m[k] = data_in[3*k +: 3];
          pend_m = 0;
        end else if (load) begin
          for (int k = 0; k < N; k++) shd_m[k] = data_in[3*k +: 3];
          pend_m = 1;
        end else if (bnd && pend_m) begin
          for (int k = 0; k < N; k++) dig_m[k] = shd_m[k];
          pend_m = 0;
        end
      end
      blank_m = blank_in;
      e.pend = pend_m;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (an !== e.an) begin
        errors++;
        $display("FAIL an at %0t: got %b want %b", $time, an, e.an);
      end
      checks++;
      if (digit_val !== e.dv) begin
        errors++;
        $display("FAIL digit_val at %0t: got %0d want %0d", $time, digit_val, e.dv);
      end
      checks++;
      if (pending !== e.pend) begin
        errors++;
        $display("FAIL pending at %0t: got %b want %b", $time, pending, e.pend);
      end
      checks++;
      if (frame_done !== e.fd) begin
        errors++;
        $display("FAIL frame_done at %0t: got %b want %b", $time, frame_done, e.fd);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL an_onehot at %0t: got %b want at most one low", $time, an);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [3*N-1:0] d);
    load = 1'b1;
    data_in = d;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_t(input int target, input string name);
    int k = 0;
    while (!(started && t == target) && k < 200) begin
      step(1);
      k++;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL %s: frame position got %0d want %0d within 200 cycles", name, t, target);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock edge.
  task automatic mid_reset();
    #2;
    reset_a = 1'b1;
    #1;
    check_val("reset_an", 32'(an), 32'(4'b1111));
    check_val("reset_pending", 32'(pending), 0);
    check_val("reset_digit_val", 32'(digit_val), 0);
    check_val("reset_frame_done", 32'(frame_done), 0);
    exp_q.delete();
    step(2);
    reset_a = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; load = 1'b0; data_in = '0; blank_in = 1'b0;
    step(3);
    reset_a = 1'b0;
    step(2);
    mid_reset();
    step(30);

    // First load and scan order
    pulse_load(12'o7531);
    check_val("first_load_an_edge_n", 32'(an), 32'(4'b1111));
    step(1);
    check_val("first_load_an_edge_n1", 32'(an), 32'(4'b1110));
    check_val("first_load_dv_edge_n1", 32'(digit_val), 1);
    step(2 * FRAME + 3);

    // Double-buffered update during digit 1
    wait_t(P + 1 + 1, "wait_digit1");
    pulse_load(12'o0246);
    step(2 * FRAME);

    // Load coincident with commit
    wait_t(2, "wait_frame_start");
    pulse_load(12'o1111);
    wait_t(FRAME - 1, "wait_boundary");
    pulse_load(12'o2222);
    step(2 * FRAME);

    // Blanking
    wait_t(7, "wait_blank_start");
    blank_in = 1'b1;
    step(25);
    blank_in = 1'b0;
    step(FRAME + 5);

    // Reset mid-scan with a pending value
    wait_t(P + 1 + 2, "wait_digit1_again");
    pulse_load(12'o3333);
    wait_t(2 * (P + 1) + 1, "wait_digit2");
    check_val("pending_before_reset", 32'(pending), 1);
    mid_reset();
    step(3);
    pulse_load(12'o4321);
    step(1);
    check_val("post_reset_an", 32'(an), 32'(4'b1110));
    check_val("post_reset_dv", 32'(digit_val), 1);
    step(FRAME);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        mid_reset();
      end
      blank_in = ($urandom_range(0, 39) == 0) ? ~blank_in : blank_in;
      if ($urandom_range(0, 11) == 0) begin
        load = 1'b1;
        data_in = 12'($urandom);
      end else begin
        load = 1'b0;
      end
      step(1);
    end
    load = 1'b0;
    blank_in = 1'b0;
    step(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_cntrl.md
# seg_scan_cntrl

Time-multiplexing scan controller for the octal seven-segment display of the sequential 8x8 multiplier. It holds up to NUM_DIGITS 3-bit digit values and presents one digit at a time to the shared `seven_segment_cntrl` decoder through `digit_val`. It drives the matching active-low anode enable and inserts a one-cycle blanking gap between digits to suppress ghosting. New values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- PRESCALE, 1000: clock cycles each digit is lit per slot (>= 1).
- clk  input  1  system clock, rising edge.
- reset_a  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe: capture `data_in`.
- data_in  input  3*NUM_DIGITS  digit values; digit k = data_in[3k+2:3k].
- blank_in  input  1  level: force all anodes off; scanning continues.
- digit_val  output  3  value for the decoder `inp`.
- an  output  NUM_DIGITS  anode enables, active-low, at most one low.
- pending  output  1  shadow register holds an uncommitted value.
- frame_done  output  1  one-cycle pulse at the end of each frame.

## Operation
- Reset: the block is asynchronous-reset only. One clock domain; reset is asynchronous and active-high on reset_a.
- Reset values: state=OFF; an=all 1; digit_val=0; pending=0; frame_done=0. All internal registers clear to 0: idx, prescaler, disp, shadow and blank_q.
- Outputs `an`, `digit_val`, `frame_done` and `pending` are registered. There is no combinational path from any input to any output.
- States: OFF, SHOW, GAP.
- OFF
  - an=all 1.
  - When load=1: disp<=data_in, idx<=0, prescaler<=0, next state SHOW. pending stays 0.
- SHOW
  - an[idx]=0 and all other anodes 1, unless blank_q=1.
  - digit_val=disp[3*idx+:3].
  - prescaler increments each cycle. When prescaler==PRESCALE-1: prescaler<=0, next state GAP.
- GAP (always exactly 1 cycle)
  - an=all 1. digit_val holds its previous value.
  - Next state SHOW with idx<=idx+1.
  - When idx==NUM_DIGITS-1, idx wraps to 0 instead, and the frame boundary actions apply:
    - frame_done=1 for this cycle.
    - If pending=1: disp<=shadow and pending<=0.
- Load while in SHOW or GAP: shadow<=data_in, pending<=1.
- A second load before the commit overwrites shadow; only the last value is committed.
- Load in the same cycle as a frame-boundary commit: disp<=data_in directly, pending<=0. The older shadow value is discarded.
- blank_in is registered into blank_q. While blank_q=1, an=all 1 in every state. idx, prescaler, state and commits advance normally.
- The block never returns to OFF except through reset_a.
- reset_a asserted mid-scan: all outputs go to their reset values immediately, without waiting for a clock edge. After release, the block waits in OFF for a load.

## Timing
- Load in OFF at edge N: an[0]=0 and digit_val=data_in[2:0] are visible after edge N+1.
- Digit slot: PRESCALE cycles lit followed by 1 gap cycle.
- Frame period: NUM_DIGITS*(PRESCALE+1) cycles.
- frame_done is asserted during the GAP cycle of the last digit. The committed disp is visible on the first SHOW cycle of digit 0 of the following frame.
- Maximum load-to-display latency in SHOW/GAP: one frame period plus 1 cycle.
- blank_in takes effect on `an` 2 edges after it changes: 1 edge into blank_q, 1 edge into the `an` register.
- Mutual exclusion: `an` never has two bits low at once. The transition between any two lit digits always passes through an all-1 cycle.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=4, frame = 20 cycles.
1. Reset and OFF hold:
   - Stimulus: assert reset_a mid-cycle, then release and apply no load for 30 cycles.
   - Required: an=4'b1111, digit_val=0, pending=0, frame_done=0 throughout.
2. First load and scan order:
   - Stimulus: load data_in=12'o7531.
   - Required: an sequence 1110(x4), 1111, 1101(x4), 1111, 1011(x4), 1111, 0111(x4), 1111, repeating.
   - Required: digit_val = 1, 3, 5, 7 on the respective digits.
   - Required: frame_done pulses every 20 cycles, in the GAP after 0111.
3. Double-buffered update:
   - Stimulus: load 12'o0246 during digit 1 of a frame.
   - Required: pending=1 until the frame_done cycle, then 0.
   - Required: the rest of the current frame still shows 7531; the next frame shows 6,4,2,0.
4. Load coincident with commit:
   - Stimulus: load 12'o1111, then load 12'o2222 exactly in a frame_done cycle.
   - Required: the next frame shows all 2s and pending=0.
5. Blanking:
   - Stimulus: hold blank_in=1 for 25 cycles.
   - Required: an=1111 from 2 edges after assertion until 2 edges after release.
   - Required: frame_done keeps pulsing every 20 cycles. Scanning resumes at the digit index the counters reached, not at digit 0.
6. Reset mid-operation:
   - Stimulus: assert reset_a during SHOW of digit 2 with pending=1.
   - Required: an=1111 and pending=0 immediately, without waiting for a clock edge.
   - Required: the next load after reset displays on digit 0 one edge later.
